// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, FIFO entry type and count-width helper for the writeback arbiter
package rf_arb_pkg;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NREG = 16;
  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wb_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry FIFO of writeback entries, two push ports (push1 implies push0), one pop.
// Ports: clk, reset_n (async, active-low); push0/din0, push1/din1 enqueue in order; pop dequeues dout;
// count is occupancy at the start of the cycle. DEPTH must be a power of two.
module rf_wb_fifo import rf_arb_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push0,
  input  logic            push1,
  input  wb_entry_t       din0,
  input  wb_entry_t       din1,
  input  logic            pop,
  output wb_entry_t       dout,
  output logic [CW-1:0]   count
);
  wb_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_q] <= din0;
    if (push1) mem_q[wr_q + PW'(1)] <= din1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push0) + PW'(push1);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU writeback (A) and buffered multiply results (B).
// Ports: clk, reset_n (async, active-low); a_* single-cycle writeback with a_grant; b_* multiply results
// (b_long = two writes) with b_ready; iss_* reserve destinations in the busy scoreboard; ra1..3/ra_en give
// hazard; rf_we/rf_wa/rf_wd drive the register file. Optional RF_WB_ARBITER_FWD_EN adds fwd_hit/fwd_data.
module rf_wb_arbiter import rf_arb_pkg::*; #(
  parameter int BUF_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  output logic          a_grant,
  input  logic          b_valid,
  input  logic          b_long,
  input  logic [AW-1:0] b_wa,
  input  logic [AW-1:0] b_wa2,
  input  logic [DW-1:0] b_wd,
  input  logic [DW-1:0] b_wd2,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic          iss_long,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] iss_rd2,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  input  logic [2:0]    ra_en,
  output logic          hazard,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
`ifdef RF_WB_ARBITER_FWD_EN
  ,
  output logic [2:0]    fwd_hit,
  output logic [DW-1:0] fwd_data
`endif
);
  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] fifo_cnt, free;
  logic [SW-1:0] starve_q, starve_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [2:0] rd_busy;
  logic empty, force_b, pop, push, push1;
  wb_entry_t head;
  rf_wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push0(push),
    .push1(push1),
    .din0('{wa: b_wa, wd: b_wd}),
    .din1('{wa: b_wa2, wd: b_wd2}),
    .pop(pop),
    .dout(head),
    .count(fifo_cnt)
  );
  assign empty = fifo_cnt == '0;
  assign free = CW'(BUF_DEPTH) - fifo_cnt;
  // readiness uses start-of-cycle occupancy; a pop in the same cycle does not free space early
  assign b_ready = reset_n && free >= (b_long ? CW'(2) : CW'(1));
  assign push = b_valid & b_ready;
  assign push1 = push & b_long;
  assign force_b = starve_q == SW'(STARVE_MAX) && !empty;
  assign pop = reset_n && !empty && (force_b || !a_valid);
  assign a_grant = reset_n && a_valid && !force_b;
  assign rf_we = pop | a_grant;
  assign rf_wa = pop ? head.wa : a_wa;
  assign rf_wd = pop ? head.wd : a_wd;
  assign rd_busy = {busy_q[ra3], busy_q[ra2], busy_q[ra1]};
`ifdef RF_WB_ARBITER_FWD_EN
  assign fwd_hit = {3{pop}} & ra_en & {ra3 == head.wa, ra2 == head.wa, ra1 == head.wa};
  assign fwd_data = rf_wd;
  assign hazard = |(ra_en & rd_busy & ~fwd_hit);
`else
  assign hazard = |(ra_en & rd_busy);
`endif
  always_comb begin
    starve_d = (empty || pop) ? '0 : (a_grant && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    busy_d = busy_q;
    if (pop) busy_d[head.wa] = 1'b0;
    // issue after the clear so a same-cycle reservation survives
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    if (iss_valid && iss_long) busy_d[iss_rd2] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      busy_q <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic clk, reset_n;
  logic a_valid, b_valid, b_long, iss_valid, iss_long;
  logic [3:0] a_wa, b_wa, b_wa2, iss_rd, iss_rd2, ra1, ra2, ra3;
  logic [31:0] a_wd, b_wd, b_wd2;
  logic [2:0] ra_en;
  logic a_grant, b_ready, hazard, rf_we;
  logic [3:0] rf_wa;
  logic [31:0] rf_wd;
`ifdef RF_WB_ARBITER_FWD_EN
  logic [2:0] fwd_hit;
  logic [31:0] fwd_data;
`endif
  int n_cmp = 0;
  int n_fail = 0;

  rf_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_grant(a_grant),
    .b_valid(b_valid), .b_long(b_long), .b_wa(b_wa), .b_wa2(b_wa2), .b_wd(b_wd), .b_wd2(b_wd2),
    .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd), .iss_rd2(iss_rd2),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .ra_en(ra_en), .hazard(hazard),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
`ifdef RF_WB_ARBITER_FWD_EN
    , .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    a_valid = 0; a_wa = 0; a_wd = 0;
    b_valid = 0; b_long = 0; b_wa = 0; b_wa2 = 0; b_wd = 0; b_wd2 = 0;
    iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rd2 = 0;
    ra1 = 0; ra2 = 0; ra3 = 0; ra_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    a_valid = 1; a_wa = 6; a_wd = 32'h1234;
    #2;
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (a_grant !== 1'b0) begin n_fail++; $display("FAIL rst_a_grant: got %b want 0", a_grant); end
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
    tick(); tick();
    idle();
    reset_n = 1;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rel_b_ready: got %b want 1", b_ready); end
  endtask

  task automatic test_reset_mid_traffic();
    idle(); iss_valid = 1; iss_rd = 5; tick();
    idle();
    a_valid = 1; b_valid = 1; b_long = 1; b_wa = 1; b_wd = 1; b_wa2 = 2; b_wd2 = 2; tick();
    b_long = 0; b_wa = 3; b_wd = 3; tick();
    b_valid = 0; ra1 = 5; ra_en = 3'b001; b_long = 1; #1;
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL mid_hazard: got %b want 1", hazard); end
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_b_ready_long3: got %b want 0", b_ready); end
    reset_n = 0; #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mrst_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (a_grant !== 1'b0) begin n_fail++; $display("FAIL mrst_a_grant: got %b want 0", a_grant); end
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_b_ready: got %b want 0", b_ready); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mrst_hazard: got %b want 0", hazard); end
    tick();
    reset_n = 1; a_valid = 0; b_long = 0; #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mrel_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL mrel_b_ready: got %b want 1", b_ready); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mrel_hazard: got %b want 0", hazard); end
    b_long = 1; #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL mrel_b_ready_long: got %b want 1", b_ready); end
    idle(); tick();
  endtask

  task automatic test_a_only();
    idle(); a_valid = 1; a_wa = 3; a_wd = 32'hDEADBEEF; #1;
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL a_rf_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_wa !== 4'd3) begin n_fail++; $display("FAIL a_rf_wa: got %0d want 3", rf_wa); end
    n_cmp++; if (rf_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_rf_wd: got %h want deadbeef", rf_wd); end
    n_cmp++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL a_grant: got %b want 1", a_grant); end
    tick(); idle();
  endtask

  task automatic test_long_mul();
    idle(); iss_valid = 1; iss_long = 1; iss_rd = 4; iss_rd2 = 5; tick();
    idle(); ra1 = 4; ra_en = 3'b000; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL lm_hazard_disabled: got %b want 0", hazard); end
    ra_en = 3'b001; #1;
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL lm_hazard_reserved: got %b want 1", hazard); end
    b_valid = 1; b_long = 1; b_wa = 4; b_wd = 32'h11; b_wa2 = 5; b_wd2 = 32'h22; #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL lm_b_ready: got %b want 1", b_ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lm_idle_we: got %b want 0", rf_we); end
    tick();
    b_valid = 0; b_long = 0; #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 4'd4 || rf_wd !== 32'h11) begin n_fail++; $display("FAIL lm_pop1: got we=%b wa=%0d wd=%h want we=1 wa=4 wd=11", rf_we, rf_wa, rf_wd); end
    n_cmp++; if (a_grant !== 1'b0) begin n_fail++; $display("FAIL lm_pop1_grant: got %b want 0", a_grant); end
`ifdef RF_WB_ARBITER_FWD_EN
    n_cmp++; if (fwd_hit !== 3'b001) begin n_fail++; $display("FAIL lm_fwd_hit: got %b want 001", fwd_hit); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL lm_pop1_hazard: got %b want 0", hazard); end
`else
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL lm_pop1_hazard: got %b want 1", hazard); end
`endif
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 4'd5 || rf_wd !== 32'h22) begin n_fail++; $display("FAIL lm_pop2: got we=%b wa=%0d wd=%h want we=1 wa=5 wd=22", rf_we, rf_wa, rf_wd); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL lm_busy4_clear: got %b want 0", hazard); end
    tick();
    ra1 = 5; #1;
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL lm_busy5_clear: got %b want 0", hazard); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lm_drained: got %b want 0", rf_we); end
    idle();
  endtask

  task automatic test_starvation();
    idle(); a_valid = 1; a_wa = 1; a_wd = 32'hA1; b_valid = 1; b_wa = 7; b_wd = 32'h77; #1;
    n_cmp++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL st_push_grant: got %b want 1", a_grant); end
    tick();
    b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_grant !== 1'b1 || rf_wa !== 4'd1) begin n_fail++; $display("FAIL st_a_win%0d: got grant=%b wa=%0d want grant=1 wa=1", i, a_grant, rf_wa); end
      tick();
    end
    #1;
    n_cmp++; if (a_grant !== 1'b0 || rf_we !== 1'b1 || rf_wa !== 4'd7 || rf_wd !== 32'h77) begin n_fail++; $display("FAIL st_forced: got grant=%b we=%b wa=%0d wd=%h want grant=0 we=1 wa=7 wd=77", a_grant, rf_we, rf_wa, rf_wd); end
    tick();
    n_cmp++; if (a_grant !== 1'b1 || rf_wa !== 4'd1) begin n_fail++; $display("FAIL st_a_again: got grant=%b wa=%0d want grant=1 wa=1", a_grant, rf_wa); end
    idle(); tick();
  endtask

  task automatic test_full();
    idle(); a_valid = 1; b_valid = 1; b_long = 1;
    b_wa = 10; b_wd = 32'h100; b_wa2 = 11; b_wd2 = 32'h101; tick();
    b_wa = 12; b_wd = 32'h102; b_wa2 = 13; b_wd2 = 32'h103; tick();
    b_long = 0; b_wa = 14; b_wd = 32'h104; #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL full_b_ready: got %b want 0", b_ready); end
    n_cmp++; if (a_grant !== 1'b1) begin n_fail++; $display("FAIL full_a_grant: got %b want 1", a_grant); end
    tick();
    a_valid = 0; b_valid = 0; #1;
    n_cmp++; if (rf_wa !== 4'd10 || rf_wd !== 32'h100) begin n_fail++; $display("FAIL full_pop0: got wa=%0d wd=%h want wa=10 wd=100", rf_wa, rf_wd); end
    tick();
    b_valid = 1; b_long = 1; #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL three_long_ready: got %b want 0", b_ready); end
    b_long = 0; #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL three_single_ready: got %b want 1", b_ready); end
    b_long = 1; #1;
    n_cmp++; if (rf_wa !== 4'd11 || rf_wd !== 32'h101) begin n_fail++; $display("FAIL full_pop1: got wa=%0d wd=%h want wa=11 wd=101", rf_wa, rf_wd); end
    tick();
    b_valid = 0; b_long = 0; #1;
    n_cmp++; if (rf_wa !== 4'd12 || rf_wd !== 32'h102) begin n_fail++; $display("FAIL full_pop2: got wa=%0d wd=%h want wa=12 wd=102", rf_wa, rf_wd); end
    tick();
    n_cmp++; if (rf_wa !== 4'd13 || rf_wd !== 32'h103) begin n_fail++; $display("FAIL full_pop3: got wa=%0d wd=%h want wa=13 wd=103", rf_wa, rf_wd); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_no_extra: got %b want 0", rf_we); end
    idle();
  endtask

  task automatic test_collision();
    idle(); b_valid = 1; b_wa = 9; b_wd = 32'h99; tick();
    idle(); iss_valid = 1; iss_rd = 9; #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 4'd9) begin n_fail++; $display("FAIL col_pop: got we=%b wa=%0d want we=1 wa=9", rf_we, rf_wa); end
    tick();
    idle(); ra1 = 9; ra_en = 3'b001; #1;
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL col_set_wins: got %b want 1", hazard); end
    b_valid = 1; b_wa = 9; b_wd = 32'h98; tick();
    b_valid = 0; #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 4'd9 || rf_wd !== 32'h98) begin n_fail++; $display("FAIL col_pop2: got we=%b wa=%0d wd=%h want we=1 wa=9 wd=98", rf_we, rf_wa, rf_wd); end
    tick();
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL col_cleared: got %b want 0", hazard); end
    idle(); iss_valid = 1; iss_rd = 2; tick();
    idle(); b_valid = 1; b_wa = 2; b_wd = 32'h2222; tick();
    idle(); ra2 = 2; ra_en = 3'b010; #1;
    n_cmp++; if (rf_wa !== 4'd2 || rf_wd !== 32'h2222) begin n_fail++; $display("FAIL col_pop_r2: got wa=%0d wd=%h want wa=2 wd=2222", rf_wa, rf_wd); end
`ifdef RF_WB_ARBITER_FWD_EN
    n_cmp++; if (fwd_hit !== 3'b010) begin n_fail++; $display("FAIL fwd_hit_r2: got %b want 010", fwd_hit); end
    n_cmp++; if (fwd_data !== 32'h2222) begin n_fail++; $display("FAIL fwd_data_r2: got %h want 2222", fwd_data); end
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL fwd_hazard_r2: got %b want 0", hazard); end
`else
    n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL wb_hazard_r2: got %b want 1", hazard); end
`endif
    tick();
    n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL r2_cleared: got %b want 0", hazard); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_a_only();
    test_long_mul();
    test_starvation();
    test_full();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
